// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI receive command path.
package spi_pkg;

   localparam int unsigned SPI_WORD_W     = 16;
   localparam int unsigned SPI_FIFO_DEPTH = 8;
   localparam int unsigned SPI_TIMEOUT    = 1023;

   typedef logic [SPI_WORD_W-1:0] spi_word_t;

   // Receiver framing state: IDLE between words, SHIFT while a word is partial.
   typedef enum logic {
      RX_IDLE  = 1'b0,
      RX_SHIFT = 1'b1
   } rx_state_e;

endpackage

// File: rtl/spi_slave_rx_if.sv
// Valid/ready word stream from the SPI receiver to instruction decode.
interface spi_slave_rx_if
   import spi_pkg::*;
#(
   parameter int unsigned WORD_W = SPI_WORD_W
);

   logic [WORD_W-1:0] word_data;
   logic              word_valid;
   logic              word_ready;

   modport master (output word_data, output word_valid, input word_ready);
   modport slave  (input word_data, input word_valid, output word_ready);

endinterface

// File: rtl/spi_rx_fifo.sv
// Synchronous first-word-fall-through FIFO with wrap-bit occupancy count.
module spi_rx_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             rd_en_c;
   logic             wr_en_c;

   // Occupancy comes from the pointer difference; the extra bit separates full from empty.
   assign count    = wr_ptr - rd_ptr;
   assign empty    = (count == CW'(0));
   assign full     = (count == CW'(DEPTH));
   assign rd_en_c  = pop & ~empty;
   assign wr_en_c  = push & (~full | rd_en_c);
   assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   // Storage array; contents are don't-care until written so no reset is needed.
   always_ff @(posedge clk) begin
      if (wr_en_c) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   // Read/write pointers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en_c) wr_ptr <= wr_ptr + CW'(1);
         if (rd_en_c) rd_ptr <= rd_ptr + CW'(1);
      end
   end

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave receiver: synchronises sclk/mosi, deserialises MSB-first words and buffers them.
module spi_slave_rx
   import spi_pkg::*;
#(
   parameter int unsigned WORD_W     = SPI_WORD_W,
   parameter int unsigned FIFO_DEPTH = SPI_FIFO_DEPTH,
   parameter int unsigned TIMEOUT    = SPI_TIMEOUT
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          spi_sclk,
   input  logic                          spi_mosi,
   spi_slave_rx_if.master                word_if,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic                          frame_err
);

   localparam int unsigned BIT_W  = $clog2(WORD_W);
   localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

   logic              sclk_s1, sclk_s2, sclk_prev;
   logic              mosi_s1, mosi_s2;
   logic [1:0]        arm_cnt;
   logic              armed;
   rx_state_e         state;
   logic [BIT_W-1:0]  bit_cnt;
   logic [WORD_W-2:0] shift_q;
   logic [IDLE_W-1:0] idle_cnt;
   logic              push_q;
   logic [WORD_W-1:0] push_data_q;
   logic              fifo_full;
   logic              fifo_empty;
   logic              rise_c;
   logic              timeout_c;
   logic              pop_c;
   logic [WORD_W-1:0] next_word_c;

   assign rise_c      = sclk_s2 & ~sclk_prev & armed;
   assign timeout_c   = (idle_cnt == IDLE_W'(TIMEOUT));
   assign next_word_c = {shift_q, mosi_s2};
   assign pop_c       = word_if.word_ready & ~fifo_empty;

   // Two-flop synchronisers plus previous-sclk flop for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_s1   <= 1'b0;
         sclk_s2   <= 1'b0;
         sclk_prev <= 1'b0;
         mosi_s1   <= 1'b0;
         mosi_s2   <= 1'b0;
      end else begin
         sclk_s1   <= spi_sclk;
         sclk_s2   <= sclk_s1;
         sclk_prev <= sclk_s2;
         mosi_s1   <= spi_mosi;
         mosi_s2   <= mosi_s1;
      end
   end

   // Hold off edge detection until the sync pipeline holds real pin samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         arm_cnt <= 2'd0;
         armed   <= 1'b0;
      end else begin
         if (arm_cnt != 2'd3) arm_cnt <= arm_cnt + 2'd1;
         if (arm_cnt == 2'd2) armed <= 1'b1;
      end
   end

   // Framing FSM: shift bits on each rise, emit full words, drop stale partial words.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RX_IDLE;
         bit_cnt     <= '0;
         shift_q     <= '0;
         idle_cnt    <= '0;
         push_q      <= 1'b0;
         push_data_q <= '0;
         frame_err   <= 1'b0;
      end else begin
         push_q    <= 1'b0;
         frame_err <= 1'b0;

         if (rise_c)         idle_cnt <= '0;
         else if (!timeout_c) idle_cnt <= idle_cnt + IDLE_W'(1);

         case (state)
            RX_IDLE: begin
               if (rise_c) begin
                  shift_q <= next_word_c[WORD_W-2:0];
                  bit_cnt <= BIT_W'(1);
                  state   <= RX_SHIFT;
               end
            end
            RX_SHIFT: begin
               if (rise_c) begin
                  shift_q <= next_word_c[WORD_W-2:0];
                  if (bit_cnt == BIT_W'(WORD_W - 1)) begin
                     push_q      <= 1'b1;
                     push_data_q <= next_word_c;
                     bit_cnt     <= '0;
                     state       <= RX_IDLE;
                  end else begin
                     bit_cnt <= bit_cnt + BIT_W'(1);
                  end
               end else if (timeout_c) begin
                  bit_cnt   <= '0;
                  shift_q   <= '0;
                  frame_err <= 1'b1;
                  state     <= RX_IDLE;
               end
            end
            default: state <= RX_IDLE;
         endcase
      end
   end

   // Sticky flag for completed words lost to a full FIFO.
   always_ff @(posedge clk) begin
      if (rst)                               overflow <= 1'b0;
      else if (push_q && fifo_full && !pop_c) overflow <= 1'b1;
   end

   spi_rx_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_q),
      .push_data (push_data_q),
      .pop       (word_if.word_ready),
      .pop_data  (word_if.word_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign word_if.word_valid = ~fifo_empty;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Testbench for spi_slave_rx: directed vectors, corner sequences and random words.
module tb_spi_slave_rx;
   import spi_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       spi_sclk;
   logic       spi_mosi;
   logic [3:0] fifo_count;
   logic       overflow;
   logic       frame_err;

   always #5 clk = ~clk;

   spi_slave_rx_if u_if ();

   spi_slave_rx dut (
      .clk        (clk),
      .rst        (rst),
      .spi_sclk   (spi_sclk),
      .spi_mosi   (spi_mosi),
      .word_if    (u_if),
      .fifo_count (fifo_count),
      .overflow   (overflow),
      .frame_err  (frame_err)
   );

   typedef struct {
      logic [15:0] data;
      logic [15:0] exp_word;
      int          exp_cnt;
   } vec_t;

   int        n_checks = 0;
   int        n_errors = 0;
   spi_word_t exp_q[$];
   int        n_rx = 0;
   int        fe_cycles = 0;
   int        last_lat;
   logic [3:0] end_cnt;
   bit        rnd_rdy = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Consumer-side scoreboard: every accepted word must match the next expected word.
   always @(negedge clk) begin
      if (!rst) begin
         if (frame_err) fe_cycles++;
         if (u_if.word_valid && u_if.word_ready) begin
            n_rx++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_word: got 0x%0h expected none at %0t", u_if.word_data, $time);
            end else begin
               check("word_data", 32'(u_if.word_data), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   // Random consumer back-pressure.
   always @(posedge clk) begin
      if (rnd_rdy) begin
         #1;
         u_if.word_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Shift out the top nbits of w MSB-first; 4 clk low / 4 clk high per bit.
   task automatic send_bits(input logic [15:0] w, input int nbits, input bit rdy_at_push);
      for (int b = 0; b < nbits; b++) begin
         spi_mosi = w[15-b];
         tick(4);
         spi_sclk = 1'b1;
         for (int i = 0; i < 4; i++) begin
            tick(1);
            if (b == nbits - 1) begin
               if (i == 2 && rdy_at_push) u_if.word_ready = 1'b1;
               if (i == 3) end_cnt = fifo_count;
               if (u_if.word_valid && last_lat == 0) last_lat = i + 1;
            end
         end
         spi_sclk = 1'b0;
      end
   endtask

   task automatic wait_drain(input int max_cyc);
      int c = 0;
      while (exp_q.size() != 0 && c < max_cyc) begin
         tick(1);
         c++;
      end
      check("drain_done", 32'(exp_q.size()), 32'd0);
      tick(3);
   endtask

   initial begin
      vec_t vecs[9];
      int   fe0;
      int   rx0;
      vecs[0] = '{16'h1001, 16'h1001, 1};
      vecs[1] = '{16'h0002, 16'h0002, 1};
      vecs[2] = '{16'h1002, 16'h1002, 1};
      vecs[3] = '{16'h0003, 16'h0003, 1};
      vecs[4] = '{16'h4000, 16'h4000, 1};
      vecs[5] = '{16'h0000, 16'h0000, 1};
      vecs[6] = '{16'hFFFF, 16'hFFFF, 1};
      vecs[7] = '{16'h8000, 16'h8000, 1};
      vecs[8] = '{16'h0001, 16'h0001, 1};

      rst = 1'b1;
      spi_sclk = 1'b0;
      spi_mosi = 1'b0;
      u_if.word_ready = 1'b0;
      tick(5);
      rst = 1'b0;
      tick(1);
      check("reset_valid", 32'(u_if.word_valid), 32'd0);
      check("reset_count", 32'(fifo_count), 32'd0);
      check("reset_overflow", 32'(overflow), 32'd0);
      check("reset_frame_err", 32'(frame_err), 32'd0);
      check("reset_data", 32'(u_if.word_data), 32'd0);
      tick(4);

      // Directed words with an always-ready consumer, incl. the back-to-back stream.
      u_if.word_ready = 1'b1;
      for (int v = 0; v < 9; v++) begin
         exp_q.push_back(vecs[v].exp_word);
         last_lat = 0;
         send_bits(vecs[v].data, 16, 1'b0);
         check("latency_le4", 32'(last_lat >= 1 && last_lat <= 4), 32'd1);
         check("count_at_push", 32'(end_cnt), 32'(vecs[v].exp_cnt));
         tick(2);
         check("count_drained", 32'(fifo_count), 32'd0);
      end
      wait_drain(50);
      check("rx_count_directed", 32'(n_rx), 32'd9);
      check("overflow_directed", 32'(overflow), 32'd0);

      // Partial word followed by a long sclk-low gap.
      fe0 = fe_cycles;
      rx0 = n_rx;
      send_bits(16'hB800, 5, 1'b0);
      tick(1100);
      check("frame_err_pulses", 32'(fe_cycles - fe0), 32'd1);
      check("timeout_no_push", 32'(n_rx - rx0), 32'd0);
      check("timeout_count", 32'(fifo_count), 32'd0);
      exp_q.push_back(16'h5000);
      send_bits(16'h5000, 16, 1'b0);
      wait_drain(50);

      // Random words with random back-pressure.
      rnd_rdy = 1'b1;
      for (int k = 0; k < 20; k++) begin
         spi_word_t w;
         w = spi_word_t'($urandom);
         exp_q.push_back(w);
         send_bits(w, 16, 1'b0);
      end
      rnd_rdy = 1'b0;
      tick(2);
      u_if.word_ready = 1'b1;
      wait_drain(100);
      check("overflow_random", 32'(overflow), 32'd0);

      // Fill to capacity, then pop in the same cycle as the next push.
      u_if.word_ready = 1'b0;
      tick(2);
      for (int k = 1; k <= 8; k++) begin
         exp_q.push_back(spi_word_t'(16'h0100 + k));
         send_bits(16'(16'h0100 + k), 16, 1'b0);
      end
      tick(3);
      check("full_count", 32'(fifo_count), 32'd8);
      exp_q.push_back(16'h0109);
      send_bits(16'h0109, 16, 1'b1);
      check("simul_count", 32'(end_cnt), 32'd8);
      check("simul_overflow", 32'(overflow), 32'd0);
      wait_drain(50);

      // Overflow: nine words into an eight-entry buffer with no consumer.
      u_if.word_ready = 1'b0;
      tick(2);
      for (int k = 1; k <= 9; k++) begin
         if (exp_q.size() < SPI_FIFO_DEPTH) exp_q.push_back(spi_word_t'(k));
         send_bits(16'(k), 16, 1'b0);
      end
      tick(3);
      check("ovf_count", 32'(fifo_count), 32'd8);
      check("ovf_flag", 32'(overflow), 32'd1);
      u_if.word_ready = 1'b1;
      wait_drain(50);
      check("ovf_drained_count", 32'(fifo_count), 32'd0);
      check("ovf_sticky", 32'(overflow), 32'd1);
      check("frame_err_total", 32'(fe_cycles), 32'd1);

      // Reset mid-word with sclk high and a buffered word pending.
      u_if.word_ready = 1'b0;
      tick(2);
      send_bits(16'hAAAA, 16, 1'b0);
      send_bits(16'hFFFF, 7, 1'b0);
      spi_sclk = 1'b1;
      tick(2);
      rst = 1'b1;
      tick(3);
      exp_q.delete();
      rst = 1'b0;
      tick(6);
      spi_sclk = 1'b0;
      tick(4);
      check("rst_mid_count", 32'(fifo_count), 32'd0);
      check("rst_mid_valid", 32'(u_if.word_valid), 32'd0);
      check("rst_mid_overflow", 32'(overflow), 32'd0);
      check("rst_mid_data", 32'(u_if.word_data), 32'd0);
      u_if.word_ready = 1'b1;
      rx0 = n_rx;
      exp_q.push_back(16'h3000);
      send_bits(16'h3000, 16, 1'b0);
      wait_drain(50);
      tick(20);
      check("rst_mid_rx", 32'(n_rx - rx0), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
